// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for Wishbone command masters and their benches:
// response status codes, FSM state encodings and termination decoding.
package wb_cmd_master_pkg;

  localparam logic [1:0] WB_RSP_OK        = 2'b00;
  localparam logic [1:0] WB_RSP_ERR       = 2'b01;
  localparam logic [1:0] WB_RSP_RETRY_EXH = 2'b10;
  localparam logic [1:0] WB_RSP_TIMEOUT   = 2'b11;

  localparam logic [1:0] WB_ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] WB_ST_REQ_ENC     = 2'd1;
  localparam logic [1:0] WB_ST_BACKOFF_ENC = 2'd2;
  localparam logic [1:0] WB_ST_RESP_ENC    = 2'd3;

  typedef enum logic [1:0] {
    WB_ST_IDLE    = WB_ST_IDLE_ENC,
    WB_ST_REQ     = WB_ST_REQ_ENC,
    WB_ST_BACKOFF = WB_ST_BACKOFF_ENC,
    WB_ST_RESP    = WB_ST_RESP_ENC
  } wb_state_e;

  typedef enum logic [1:0] {
    WB_TERM_NONE = 2'd0,
    WB_TERM_ACK  = 2'd1,
    WB_TERM_ERR  = 2'd2,
    WB_TERM_RTY  = 2'd3
  } wb_term_e;

  // Resolve simultaneous slave terminations: ack wins over err, err over rty.
  function automatic wb_term_e wb_term_decode(input logic ack, input logic err, input logic rty);
    wb_term_e term;
    if (ack) begin
      term = WB_TERM_ACK;
    end else if (err) begin
      term = WB_TERM_ERR;
    end else if (rty) begin
      term = WB_TERM_RTY;
    end else begin
      term = WB_TERM_NONE;
    end
    return term;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic-cycle master. A command accepted on the
// valid/ready command port becomes one bus cycle (plus retries); the outcome is
// returned on the valid/ready response port. A watchdog aborts cycles that a
// slave never terminates.
module wb_cmd_master #(
  parameter int Dw        = 32,
  parameter int Aw        = 32,
  parameter int SELw      = 4,
  parameter int TAGw      = 3,
  parameter int TIMEOUTw  = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [Aw-1:0]   cmd_addr,
  input  logic [Dw-1:0]   cmd_dat,
  input  logic [SELw-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [Dw-1:0]   rsp_dat,
  output logic [1:0]      rsp_status,
  output logic [Dw-1:0]   ma_dat_o,
  output logic [SELw-1:0] ma_sel_o,
  output logic [Aw-1:0]   ma_addr_o,
  output logic [TAGw-1:0] ma_tag_o,
  output logic            ma_stb_o,
  output logic            ma_cyc_o,
  output logic            ma_we_o,
  input  logic [Dw-1:0]   ma_dat_i,
  input  logic            ma_ack_i,
  input  logic            ma_err_i,
  input  logic            ma_rty_i
);
  import wb_cmd_master_pkg::*;

  // Retry counter must hold values 0..MAX_RETRY.
  localparam int RETRYw = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRYw-1:0] RETRY_LIM = RETRYw'(MAX_RETRY);

  // Watchdog fires on the TIMEOUT-th consecutive unterminated REQ cycle.
  localparam bit                  WDOG_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUTw-1:0] WDOG_LAST = TIMEOUTw'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  wb_state_e state_q, state_d;

  logic [RETRYw-1:0]   retry_q, retry_d;
  logic [TIMEOUTw-1:0] wdog_q, wdog_d;

  logic            cyc_d, stb_d, we_d;
  logic [Aw-1:0]   addr_d;
  logic [Dw-1:0]   dat_d;
  logic [SELw-1:0] sel_d;
  logic            rsp_valid_d;
  logic [Dw-1:0]   rsp_dat_d;
  logic [1:0]      rsp_status_d;

  wb_term_e term;
  logic     cmd_accept;
  logic     retry_ok;
  logic     wdog_fire;

  // Ready is combinational so a command can be taken in the first IDLE cycle.
  assign cmd_ready  = (state_q == WB_ST_IDLE) & ~reset;
  assign cmd_accept = cmd_valid & cmd_ready;
  assign ma_tag_o   = '0;

  assign term      = wb_term_decode(ma_ack_i, ma_err_i, ma_rty_i);
  assign retry_ok  = (retry_q < RETRY_LIM);
  assign wdog_fire = WDOG_EN && (wdog_q == WDOG_LAST);

  // State and all registered bus/response outputs; reset drops the cycle at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WB_ST_IDLE;
      retry_q    <= '0;
      wdog_q     <= '0;
      ma_cyc_o   <= 1'b0;
      ma_stb_o   <= 1'b0;
      ma_we_o    <= 1'b0;
      ma_addr_o  <= '0;
      ma_dat_o   <= '0;
      ma_sel_o   <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= WB_RSP_OK;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      wdog_q     <= wdog_d;
      ma_cyc_o   <= cyc_d;
      ma_stb_o   <= stb_d;
      ma_we_o    <= we_d;
      ma_addr_o  <= addr_d;
      ma_dat_o   <= dat_d;
      ma_sel_o   <= sel_d;
      rsp_valid  <= rsp_valid_d;
      rsp_dat    <= rsp_dat_d;
      rsp_status <= rsp_status_d;
    end
  end

  // Next-state: IDLE -> REQ -> (BACKOFF -> REQ)* -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_ST_IDLE: begin
        if (cmd_accept) begin
          state_d = WB_ST_REQ;
        end
      end
      WB_ST_REQ: begin
        unique case (term)
          WB_TERM_ACK, WB_TERM_ERR: state_d = WB_ST_RESP;
          WB_TERM_RTY:              state_d = retry_ok ? WB_ST_BACKOFF : WB_ST_RESP;
          default: begin
            if (wdog_fire) begin
              state_d = WB_ST_RESP;
            end
          end
        endcase
      end
      WB_ST_BACKOFF: begin
        state_d = WB_ST_REQ;
      end
      WB_ST_RESP: begin
        if (rsp_ready) begin
          state_d = WB_ST_IDLE;
        end
      end
      default: state_d = WB_ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters for each state.
  always_comb begin
    cyc_d        = ma_cyc_o;
    stb_d        = ma_stb_o;
    we_d         = ma_we_o;
    addr_d       = ma_addr_o;
    dat_d        = ma_dat_o;
    sel_d        = ma_sel_o;
    rsp_valid_d  = rsp_valid;
    rsp_dat_d    = rsp_dat;
    rsp_status_d = rsp_status;
    retry_d      = retry_q;
    wdog_d       = wdog_q;
    unique case (state_q)
      WB_ST_IDLE: begin
        if (cmd_accept) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          retry_d = '0;
          wdog_d  = '0;
        end
      end
      WB_ST_REQ: begin
        unique case (term)
          WB_TERM_ACK: begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_dat_d    = ma_we_o ? '0 : ma_dat_i;
            rsp_status_d = WB_RSP_OK;
          end
          WB_TERM_ERR: begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_dat_d    = '0;
            rsp_status_d = WB_RSP_ERR;
          end
          WB_TERM_RTY: begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            if (retry_ok) begin
              retry_d = retry_q + RETRYw'(1);
            end else begin
              rsp_valid_d  = 1'b1;
              rsp_dat_d    = '0;
              rsp_status_d = WB_RSP_RETRY_EXH;
            end
          end
          default: begin
            if (wdog_fire) begin
              cyc_d        = 1'b0;
              stb_d        = 1'b0;
              rsp_valid_d  = 1'b1;
              rsp_dat_d    = '0;
              rsp_status_d = WB_RSP_TIMEOUT;
            end else begin
              wdog_d = wdog_q + TIMEOUTw'(1);
            end
          end
        endcase
      end
      WB_ST_BACKOFF: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        wdog_d = '0;
      end
      WB_ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          retry_d     = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized scoreboard bench for wb_cmd_master with a scripted stub slave.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int TO = 16;
  localparam int MR = 3;

  localparam int FIN_ACK    = 0;
  localparam int FIN_ERR    = 1;
  localparam int FIN_ACKERR = 2;
  localparam int FIN_NONE   = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_c;
    int          n_rty;
    int          fin;
    int          hold;
  } txn_t;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] dat;
    int          hold;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] ma_dat_o;
  logic [3:0]  ma_sel_o;
  logic [31:0] ma_addr_o;
  logic [2:0]  ma_tag_o;
  logic        ma_stb_o;
  logic        ma_cyc_o;
  logic        ma_we_o;
  logic [31:0] ma_dat_i;
  logic        ma_ack_i;
  logic        ma_err_i;
  logic        ma_rty_i;

  int checks = 0;
  int errors = 0;

  txn_t txn_q[$];
  exp_t exp_q[$];

  logic [31:0] model_mem [8];
  logic [31:0] s_mem [8];

  wb_cmd_master #(
    .Dw(32), .Aw(32), .SELw(4), .TAGw(3),
    .TIMEOUTw(8), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .ma_dat_o(ma_dat_o), .ma_sel_o(ma_sel_o), .ma_addr_o(ma_addr_o), .ma_tag_o(ma_tag_o),
    .ma_stb_o(ma_stb_o), .ma_cyc_o(ma_cyc_o), .ma_we_o(ma_we_o),
    .ma_dat_i(ma_dat_i), .ma_ack_i(ma_ack_i), .ma_err_i(ma_err_i), .ma_rty_i(ma_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: outcome of a command follows from the slave script alone.
  task automatic model_predict(input txn_t t, output exp_t e);
    logic [2:0] idx;
    idx    = t.addr[2:0];
    e.hold = t.hold;
    e.dat  = 32'h0;
    if (t.n_rty > MR) begin
      e.status = WB_RSP_RETRY_EXH;
    end else if (t.fin == FIN_NONE) begin
      e.status = WB_RSP_TIMEOUT;
    end else if (t.fin == FIN_ERR) begin
      e.status = WB_RSP_ERR;
    end else begin
      e.status = WB_RSP_OK;
      if (t.we) begin
        for (int b = 0; b < 4; b++) begin
          if (t.sel[b]) model_mem[idx][8*b +: 8] = t.dat[8*b +: 8];
        end
      end else begin
        e.dat = model_mem[idx];
      end
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                              input logic [3:0] sel, input int wait_c, input int n_rty,
                              input int fin, input int hold);
    txn_t t;
    t.we = we; t.addr = addr; t.dat = dat; t.sel = sel;
    t.wait_c = wait_c; t.n_rty = n_rty; t.fin = fin; t.hold = hold;
    return t;
  endfunction

  task automatic make_random(output txn_t t);
    int r;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = $urandom;
    t.dat  = $urandom;
    t.sel  = 4'($urandom_range(0, 15));
    r = $urandom_range(0, 9);
    t.wait_c = (r < 6) ? $urandom_range(0, 2) : ((r < 9) ? $urandom_range(3, 10) : 15);
    r = $urandom_range(0, 9);
    t.n_rty = (r < 5) ? 0 : ((r < 8) ? $urandom_range(1, 3) : 4);
    r = $urandom_range(0, 19);
    t.fin = (r < 12) ? FIN_ACK : ((r < 15) ? FIN_ERR : ((r < 18) ? FIN_ACKERR : FIN_NONE));
    t.hold = $urandom_range(0, 3);
  endtask

  // Issue one command when the master is ready; expected response goes to the scoreboard.
  task automatic apply_stimulus(input txn_t t, input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_output("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      return;
    end
    model_predict(t, e);
    txn_q.push_back(t);
    if (expect_rsp) exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_we    = t.we;
    cmd_addr  = t.addr;
    cmd_dat   = t.dat;
    cmd_sel   = t.sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom_range(0, 15));
    check_output("cmd_ready_after_accept", 32'(cmd_ready), 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid || !cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_in_time", 32'(n < 2000), 32'h1);
  endtask

  // Stub slave: follows each command's script, checks bus stability, phase length and backoff gap.
  txn_t s_t;
  bit   s_active;
  int   s_phase, s_gap, s_k, exp_len;
  initial begin
    ma_ack_i = 1'b0; ma_err_i = 1'b0; ma_rty_i = 1'b0; ma_dat_i = 32'h0;
    s_active = 1'b0; s_phase = 0; s_gap = 0; s_k = 0;
    s_t = mk(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, FIN_ACK, 0);
    for (int i = 0; i < 8; i++) begin
      s_mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end
    forever begin
      @(negedge clk);
      ma_ack_i = 1'b0; ma_err_i = 1'b0; ma_rty_i = 1'b0;
      ma_dat_i = $urandom;
      if (reset) begin
        s_active = 1'b0; s_phase = 0; s_gap = 0; s_k = 0;
      end else if (ma_cyc_o && ma_stb_o) begin
        if (s_phase == 0 && !s_active) begin
          if (txn_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL slave_cycle: bus cycle started with no command issued");
          end else begin
            s_t = txn_q.pop_front();
            s_active = 1'b1;
            s_k = 0;
          end
        end else if (s_phase == 0) begin
          check_output("backoff_gap", 32'(s_gap), 32'h1);
        end
        check_output("bus_addr", ma_addr_o, s_t.addr);
        check_output("bus_we", 32'(ma_we_o), 32'(s_t.we));
        check_output("bus_sel", 32'(ma_sel_o), 32'(s_t.sel));
        check_output("bus_tag", 32'(ma_tag_o), 32'h0);
        if (s_t.we) check_output("bus_wdat", ma_dat_o, s_t.dat);
        s_phase++;
        if (!ma_we_o) ma_dat_i = s_mem[ma_addr_o[2:0]];
        if (s_phase - 1 == s_t.wait_c) begin
          if (s_k < s_t.n_rty) begin
            ma_rty_i = 1'b1;
          end else begin
            case (s_t.fin)
              FIN_ACK:    begin ma_ack_i = 1'b1; ma_rty_i = 1'($urandom_range(0, 1)); end
              FIN_ERR:    begin ma_err_i = 1'b1; ma_rty_i = 1'($urandom_range(0, 1)); end
              FIN_ACKERR: begin ma_ack_i = 1'b1; ma_err_i = 1'b1; end
              default: ;
            endcase
          end
          if (ma_ack_i && ma_we_o) begin
            for (int b = 0; b < 4; b++) begin
              if (ma_sel_o[b]) s_mem[ma_addr_o[2:0]][8*b +: 8] = ma_dat_o[8*b +: 8];
            end
          end
        end
      end else begin
        if (s_phase > 0) begin
          exp_len = (s_k < s_t.n_rty || s_t.fin != FIN_NONE) ? s_t.wait_c + 1 : TO;
          check_output("req_cycles", 32'(s_phase), 32'(exp_len));
          if (s_k < s_t.n_rty && s_k < MR) s_k++;
          else s_active = 1'b0;
          s_phase = 0;
          s_gap = 0;
        end
        if (s_active) s_gap++;
        // Stray terminations while no strobe is up must be ignored by the master.
        if ($urandom_range(0, 3) == 0) begin
          ma_ack_i = 1'($urandom_range(0, 1));
          ma_err_i = 1'($urandom_range(0, 1));
          ma_rty_i = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and checks it every held cycle.
  exp_t m_exp;
  bit   m_have, m_cmp;
  int   m_hold;
  initial begin
    rsp_ready = 1'b0; m_have = 1'b0; m_cmp = 1'b0; m_hold = 0;
    m_exp.status = 2'b00; m_exp.dat = 32'h0; m_exp.hold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_have = 1'b0; m_cmp = 1'b0; rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        check_output("cmd_ready_while_rsp", 32'(cmd_ready), 32'h0);
        if (!m_have) begin
          m_have = 1'b1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_rsp: status %0d dat 0x%08h with empty scoreboard", rsp_status, rsp_dat);
            m_cmp = 1'b0; m_hold = 0;
          end else begin
            m_exp = exp_q.pop_front();
            m_cmp = 1'b1;
            m_hold = m_exp.hold;
          end
        end
        if (m_cmp) begin
          check_output("rsp_status", 32'(rsp_status), 32'(m_exp.status));
          check_output("rsp_dat", rsp_dat, m_exp.dat);
        end
        if (m_hold > 0) begin
          rsp_ready = 1'b0;
          m_hold--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready) begin
          m_have = 1'b0; m_cmp = 1'b0;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] aborted");
  end

  // Main sequence: reset checks, directed corner cases, random traffic, reset mid-cycle.
  initial begin
    txn_t t;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
    repeat (3) @(negedge clk);
    check_output("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset_cyc", 32'(ma_cyc_o), 32'h0);
    check_output("reset_stb", 32'(ma_stb_o), 32'h0);
    check_output("reset_addr", ma_addr_o, 32'h0);
    check_output("reset_rsp_dat", rsp_dat, 32'h0);
    check_output("reset_rsp_status", 32'(rsp_status), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check_output("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

    $display("[TB] directed cases");
    apply_stimulus(mk(1'b1, 32'h2, 32'h0000_0064, 4'hF, 1, 0, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h2, 32'h0, 4'hF, 1, 0, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h2, 32'h0, 4'hF, 0, 2, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b1, 32'h2, 32'h1234_5678, 4'hF, 0, 4, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h1, 32'h0, 4'hF, 0, 0, FIN_NONE, 0), 1'b1);
    apply_stimulus(mk(1'b1, 32'h5, 32'hA5A5_A5A5, 4'hF, 0, 0, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h5, 32'h0, 4'hF, 0, 0, FIN_ACKERR, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h5, 32'h0, 4'hF, 0, 0, FIN_ERR, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h5, 32'h0, 4'hF, 15, 0, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h2, 32'h0, 4'hF, 10, 3, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h5, 32'h0, 4'hF, 0, 0, FIN_ACK, 10), 1'b1);
    apply_stimulus(mk(1'b1, 32'h3, 32'h1122_3344, 4'b0101, 0, 0, FIN_ACK, 0), 1'b1);
    apply_stimulus(mk(1'b0, 32'h3, 32'h0, 4'hF, 0, 0, FIN_ACK, 0), 1'b1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      make_random(t);
      apply_stimulus(t, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] reset during REQ");
    apply_stimulus(mk(1'b0, 32'h1, 32'h0, 4'hF, 0, 0, FIN_NONE, 0), 1'b0);
    repeat (2) @(negedge clk);
    check_output("pre_reset_cyc", 32'(ma_cyc_o), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_cyc", 32'(ma_cyc_o), 32'h0);
    check_output("midreset_stb", 32'(ma_stb_o), 32'h0);
    check_output("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("midreset_cmd_ready", 32'(cmd_ready), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check_output("postreset_cmd_ready", 32'(cmd_ready), 32'h1);
    apply_stimulus(mk(1'b0, 32'h3, 32'h0, 4'hF, 1, 1, FIN_ACK, 0), 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
